// File: rtl/fifo_fill_pkg.sv
// Shared types and default geometry for the delay fifo fill controller.
package fifo_fill_pkg;

    typedef enum logic [1:0] {LOAD, DRAIN, FINISH} state_t;

    localparam int NUM_FIFOS_DFLT = 8;
    localparam int DEPTH_DFLT     = 8;
    localparam int BITS_DFLT      = 64;

    localparam int LANE_W  = $clog2(NUM_FIFOS_DFLT);
    localparam int CNT_W   = $clog2(DEPTH_DFLT + 1);
    localparam int DRAIN_W = $clog2(DEPTH_DFLT + NUM_FIFOS_DFLT - 1);

endpackage

// File: rtl/lane_fill_counter.sv
// Per-lane fill level: saturates at DEPTH, cleared after a drain; full is a
// decode of the registered count.
module lane_fill_counter
    import fifo_fill_pkg::*;
#(
    parameter int DEPTH = DEPTH_DFLT,
    parameter int W     = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(DEPTH))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign full = (cnt == W'(DEPTH));

endmodule

// File: rtl/fifo_fill_ctrl.sv
// Steers host words into delay fifo lanes (1-cycle latency), then drains all lanes;
// FIFO_FILL_CTRL_SKEW_EN selects the systolic skewed drain, otherwise all lanes drain together.
module fifo_fill_ctrl
    import fifo_fill_pkg::*;
#(
    parameter  int NUM_FIFOS = NUM_FIFOS_DFLT,
    parameter  int DEPTH     = DEPTH_DFLT,
    parameter  int BITS      = BITS_DFLT,
    localparam int SW = (NUM_FIFOS == NUM_FIFOS_DFLT) ? LANE_W : $clog2(NUM_FIFOS),
    localparam int CW = (DEPTH == DEPTH_DFLT) ? CNT_W : $clog2(DEPTH + 1),
    localparam int TW = ((NUM_FIFOS == NUM_FIFOS_DFLT) && (DEPTH == DEPTH_DFLT))
                        ? DRAIN_W : $clog2(DEPTH + NUM_FIFOS - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SW-1:0]        in_sel,
    input  logic [BITS-1:0]      in_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_FIFOS-1:0] fifo_en,
    output logic [BITS-1:0]      fifo_d,
    output logic [NUM_FIFOS-1:0] lane_valid,
    output logic                 err
);

`ifdef FIFO_FILL_CTRL_SKEW_EN
    localparam int LAST = DEPTH + NUM_FIFOS - 2;
`else
    localparam int LAST = DEPTH - 1;
`endif

    function automatic logic [NUM_FIFOS-1:0] drain_en(input int tt);
        drain_en = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
`ifdef FIFO_FILL_CTRL_SKEW_EN
            drain_en[i] = (tt >= i) && (tt < i + DEPTH);
`else
            drain_en[i] = (tt < DEPTH);
`endif
        end
    endfunction

    state_t                state;
    logic [TW-1:0]         t;
    logic [NUM_FIFOS-1:0]  full;
    logic [NUM_FIFOS-1:0]  sel_hit;
    logic [NUM_FIFOS-1:0]  inc;
    logic                  acc, start_ok, wr_ok, clr;

    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            sel_hit[i] = (int'(in_sel) == i);
        end
        acc      = (state == LOAD) && in_valid && in_ready;
        // start qualifies on the counts before this cycle's write lands
        start_ok = (state == LOAD) && start && (&full);
        wr_ok    = acc && (|sel_hit) && !(|(sel_hit & full)) && !start_ok;
        inc      = wr_ok ? sel_hit : '0;
        clr      = (state == FINISH);
    end

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_lane
        lane_fill_counter #(.DEPTH(DEPTH), .W(CW)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[g]),
            .clr  (clr),
            .full (full[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            t          <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fifo_en    <= '0;
            fifo_d     <= '0;
            lane_valid <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    done       <= 1'b0;
                    lane_valid <= '0;
                    if (start_ok) begin
                        state      <= DRAIN;
                        t          <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        fifo_d     <= '0;
                        fifo_en    <= drain_en(0);
                        lane_valid <= drain_en(0);
                    end else begin
                        if (start) err <= 1'b1;
                        if (wr_ok) begin
                            fifo_en <= sel_hit;
                            fifo_d  <= in_data;
                        end else begin
                            fifo_en <= '0;
                        end
                    end
                    if (acc && !wr_ok) err <= 1'b1;
                end
                DRAIN: begin
                    if (int'(t) == LAST) begin
                        state      <= FINISH;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fifo_en    <= '0;
                        lane_valid <= '0;
                    end else begin
                        t          <= t + 1'b1;
                        fifo_en    <= drain_en(int'(t) + 1);
                        lane_valid <= drain_en(int'(t) + 1);
                    end
                end
                FINISH: begin
                    state    <= LOAD;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench for fifo_fill_ctrl with a behavioural delay fifo bank on its outputs.
module tb_fifo_fill_ctrl;

    localparam int NF = 8;
    localparam int D  = 8;
`ifdef FIFO_FILL_CTRL_SKEW_EN
    localparam int LAST = D + NF - 2;
`else
    localparam int LAST = D - 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [63:0] in_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  fifo_en;
    logic [63:0] fifo_d;
    logic [7:0]  lane_valid;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fifo_en    (fifo_en),
        .fifo_d     (fifo_d),
        .lane_valid (lane_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    // delay fifo bank: shift in at [0], head q is [D-1]
    logic [63:0] mem [NF][D];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NF; i++)
                for (int j = 0; j < D; j++)
                    mem[i][j] <= '0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (fifo_en[i]) begin
                    mem[i][0] <= fifo_d;
                    for (int j = 1; j < D; j++)
                        mem[i][j] <= mem[i][j-1];
                end
            end
        end
    end

    function automatic logic [63:0] word(input int l, input int k);
        word = (64'(l) << 16) | 64'(k);
    endfunction

    function automatic logic [7:0] exp_en(input int tt);
        exp_en = '0;
        for (int i = 0; i < NF; i++) begin
`ifdef FIFO_FILL_CTRL_SKEW_EN
            exp_en[i] = (tt >= i) && (tt < i + D);
`else
            exp_en[i] = 1'b1;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; in_sel = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, busy, done, err} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctl: got rdy/busy/done/err=%b want 1000", {in_ready, busy, done, err});
        end
        n_cmp++;
        if ({fifo_en, lane_valid, fifo_d} !== 80'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got en=%h lv=%h d=%h want all zero", fifo_en, lane_valid, fifo_d);
        end
        rst = 1'b0;
        tick();
    endtask

    // loads every lane with words idx 0..7; short_lane (if >=0) gets only 7
    task automatic test_fill(input int short_lane);
        for (int l = 0; l < NF; l++) begin
            for (int k = 0; k < D; k++) begin
                if (l == short_lane && k == D - 1) continue;
                in_valid = 1'b1; in_sel = 3'(l); in_data = word(l, k);
                tick();
                n_cmp++;
                if ({fifo_en, fifo_d} !== {8'(1 << l), word(l, k)}) begin
                    n_bad++;
                    $display("FAIL fill_l%0d_k%0d: got en=%h d=%h want en=%h d=%h",
                             l, k, fifo_en, fifo_d, 8'(1 << l), word(l, k));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain(input bit with_write);
        logic [7:0] e;
        int idx;
        start = 1'b1;
        if (with_write) begin
            in_valid = 1'b1; in_sel = 3'd3; in_data = 64'hffff_ffff_ffff_ffff;
        end
        tick();
        start = 1'b0; in_valid = 1'b0;
        for (int t = 0; t <= LAST; t++) begin
            e = exp_en(t);
            n_cmp++;
            if ({busy, in_ready, done, fifo_en, lane_valid, fifo_d} !== {3'b100, e, e, 64'h0}) begin
                n_bad++;
                $display("FAIL drain_t%0d: got busy/rdy/done=%b en=%h lv=%h d=%h want 100 en=%h lv=%h d=0",
                         t, {busy, in_ready, done}, fifo_en, lane_valid, fifo_d, e, e);
            end
            for (int i = 0; i < NF; i++) begin
                if (e[i]) begin
`ifdef FIFO_FILL_CTRL_SKEW_EN
                    idx = t - i;
`else
                    idx = t;
`endif
                    n_cmp++;
                    if (mem[i][D-1] !== word(i, idx)) begin
                        n_bad++;
                        $display("FAIL drain_q_t%0d_l%0d: got %h want %h", t, i, mem[i][D-1], word(i, idx));
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if ({busy, done, in_ready, fifo_en, lane_valid} !== {3'b010, 16'h0}) begin
            n_bad++;
            $display("FAIL finish: got busy/done/rdy=%b en=%h lv=%h want 010 0 0",
                     {busy, done, in_ready}, fifo_en, lane_valid);
        end
        tick();
        n_cmp++;
        if ({busy, done, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL after_finish: got busy/done/rdy=%b want 001", {busy, done, in_ready});
        end
    endtask

    task automatic test_overflow();
        test_reset();
        test_fill(-1);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_err: got %b want 0", err);
        end
        in_valid = 1'b1; in_sel = 3'd2; in_data = 64'hdead;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({fifo_en, err} !== 9'b0_0000_0001) begin
            n_bad++;
            $display("FAIL ninth_write: got en=%h err=%b want en=00 err=1", fifo_en, err);
        end
        repeat (3) tick();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        test_drain(1'b0);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky_drain: got %b want 1", err);
        end
    endtask

    task automatic test_start_not_full();
        test_reset();
        test_fill(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({busy, in_ready, err} !== 3'b011) begin
                n_bad++;
                $display("FAIL early_start_c%0d: got busy/rdy/err=%b want 011", c, {busy, in_ready, err});
            end
            tick();
        end
        in_valid = 1'b1; in_sel = 3'd5; in_data = word(5, 7);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (fifo_en !== 8'h20) begin
            n_bad++;
            $display("FAIL lane5_last: got en=%h want 20", fifo_en);
        end
        test_drain(1'b0);
    endtask

    task automatic test_start_with_last_write();
        test_reset();
        test_fill(7);
        start = 1'b1; in_valid = 1'b1; in_sel = 3'd7; in_data = word(7, 7);
        tick();
        start = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if ({fifo_en, fifo_d, busy, err} !== {8'h80, word(7, 7), 2'b01}) begin
            n_bad++;
            $display("FAIL last_write_start: got en=%h d=%h busy=%b err=%b want 80 %h 0 1",
                     fifo_en, fifo_d, busy, err, word(7, 7));
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL last_write_start_idle: got busy=%b want 0", busy);
        end
        test_drain(1'b0);
    endtask

    task automatic test_write_on_start();
        test_reset();
        test_fill(-1);
        test_drain(1'b1);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL write_on_start_err: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_drain();
        test_reset();
        test_fill(-1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if ({busy, fifo_en} !== {1'b1, exp_en(4)}) begin
            n_bad++;
            $display("FAIL mid_drain_t4: got busy=%b en=%h want 1 %h", busy, fifo_en, exp_en(4));
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({in_ready, busy, done, err, fifo_en, lane_valid, fifo_d} !== {4'b1000, 80'h0}) begin
            n_bad++;
            $display("FAIL mid_drain_rst: got rdy/busy/done/err=%b en=%h lv=%h d=%h want 1000 0 0 0",
                     {in_ready, busy, done, err}, fifo_en, lane_valid, fifo_d);
        end
        rst = 1'b0;
        tick();
        test_fill(-1);
        test_drain(1'b0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_err: got %b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_fill(-1);
        test_drain(1'b0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_run_err: got %b want 0", err);
        end
        test_overflow();
        test_start_not_full();
        test_start_with_last_write();
        test_write_on_start();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
